alu_issue_stage: RTL and testbench

//  Decode/issue stage feeding the ALU. Accepts fetched RV32I words, decodes OP, OP-IMM, LUI and AUIPC

---
 rtl/alu_issue_stage_pkg.sv | 43 ++++
 rtl/alu_issue_stage_reg_file.sv | 44 ++++
 rtl/alu_issue_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared types and decode constants for the ALU decode/issue stage.
package alu_issue_stage_pkg;

    typedef logic signed [31:0] t_word;
    typedef logic [31:0]        t_uword;
    typedef logic [4:0]         t_reg_idx;

    typedef enum logic [3:0] {
        FK_ADD  = 4'd0,
        FK_SUB  = 4'd1,
        FK_SLL  = 4'd2,
        FK_SLT  = 4'd3,
        FK_SLTU = 4'd4,
        FK_XOR  = 4'd5,
        FK_SRL  = 4'd6,
        FK_SRA  = 4'd7,
        FK_OR   = 4'd8,
        FK_AND  = 4'd9
    } t_func_kind;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // The ALU shifts by the full operand, so shift amounts are cut to 5 bits here.
    function automatic t_uword shamt_mask(input t_uword v);
        return {27'd0, v[4:0]};
    endfunction

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// Register file: two read ports, one write port, write-through bypass, x0 reads zero.
module alu_issue_stage_reg_file
    import alu_issue_stage_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    t_uword regs_q [NUM_REGS];
    t_uword regs_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (we && (waddr == 5'(i)) && (i != 0)) ? wdata : regs_q[i];
        end
    end

    always_comb begin
        rdata_a = (raddr_a == 5'd0) ? 32'd0 :
                  (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
        rdata_b = (raddr_b == 5'd0) ? 32'd0 :
                  (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes OP/OP-IMM/LUI/AUIPC, checks the scoreboard, and holds one
// registered issue slot toward the ALU. This block keeps no PC of its own.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output t_func_kind  out_func,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    localparam logic [NUM_REGS-1:0] ONE_BIT = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [6:0] opcode_s, funct7_s;
    logic [2:0] funct3_s;
    t_reg_idx   rd_s, rs1_s, rs2_s;
    t_uword     imm_i_s, imm_u_s, rs1_data_s, rs2_data_s;

    assign opcode_s = in_instr[6:0];
    assign rd_s     = in_instr[11:7];
    assign funct3_s = in_instr[14:12];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign funct7_s = in_instr[31:25];
    assign imm_i_s  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u_s  = {in_instr[31:12], 12'd0};

    alu_issue_stage_reg_file #(.NUM_REGS(NUM_REGS)) u_reg_file (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs1_s),
        .rdata_a (rs1_data_s),
        .raddr_b (rs2_s),
        .rdata_b (rs2_data_s)
    );

    logic                out_valid_q, out_valid_d;
    t_func_kind          out_func_q, out_func_d;
    t_uword              out_a_q, out_a_d, out_b_q, out_b_d;
    t_reg_idx            out_rd_q, out_rd_d;
    logic                out_we_q, out_we_d, out_illegal_q, out_illegal_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    t_func_kind raw_func_s, dec_func_s;
    t_uword     raw_a_s, raw_b_s, dec_a_s, dec_b_s;
    logic       legal_s, raw_rs1_s, raw_rs2_s, use_rs1_s, use_rs2_s, dec_we_s;

    always_comb begin
        raw_func_s = FK_ADD;
        raw_a_s    = 32'd0;
        raw_b_s    = 32'd0;
        legal_s    = 1'b0;
        raw_rs1_s  = 1'b0;
        raw_rs2_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                raw_rs1_s = 1'b1;
                raw_rs2_s = 1'b1;
                raw_a_s   = rs1_data_s;
                raw_b_s   = rs2_data_s;
                if (funct7_s == F7_BASE) begin
                    legal_s = 1'b1;
                    case (funct3_s)
                        F3_ADD:  raw_func_s = FK_ADD;
                        F3_SLL:  begin raw_func_s = FK_SLL; raw_b_s = shamt_mask(rs2_data_s); end
                        F3_SLT:  raw_func_s = FK_SLT;
                        F3_SLTU: raw_func_s = FK_SLTU;
                        F3_XOR:  raw_func_s = FK_XOR;
                        F3_SRL:  begin raw_func_s = FK_SRL; raw_b_s = shamt_mask(rs2_data_s); end
                        F3_OR:   raw_func_s = FK_OR;
                        F3_AND:  raw_func_s = FK_AND;
                        default: legal_s = 1'b0;
                    endcase
                end else if ((funct7_s == F7_ALT) && (funct3_s == F3_ADD)) begin
                    legal_s    = 1'b1;
                    raw_func_s = FK_SUB;
                end else if ((funct7_s == F7_ALT) && (funct3_s == F3_SRL)) begin
                    legal_s    = 1'b1;
                    raw_func_s = FK_SRA;
                    raw_b_s    = shamt_mask(rs2_data_s);
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                raw_rs1_s = 1'b1;
                raw_a_s   = rs1_data_s;
                raw_b_s   = imm_i_s;
                legal_s   = 1'b1;
                case (funct3_s)
                    F3_ADD:  raw_func_s = FK_ADD;
                    F3_SLT:  raw_func_s = FK_SLT;
                    F3_SLTU: raw_func_s = FK_SLTU;
                    F3_XOR:  raw_func_s = FK_XOR;
                    F3_OR:   raw_func_s = FK_OR;
                    F3_AND:  raw_func_s = FK_AND;
                    F3_SLL: begin
                        raw_func_s = FK_SLL;
                        raw_b_s    = shamt_mask(imm_i_s);
                        legal_s    = (funct7_s == F7_BASE);
                    end
                    F3_SRL: begin
                        raw_func_s = (funct7_s == F7_ALT) ? FK_SRA : FK_SRL;
                        raw_b_s    = shamt_mask(imm_i_s);
                        legal_s    = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal_s = 1'b1;
                raw_b_s = imm_u_s;
            end
            OPC_AUIPC: begin
                legal_s = 1'b1;
                raw_a_s = in_pc;
                raw_b_s = imm_u_s;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Illegal words carry no operands and read no registers, so they never stall.
    always_comb begin
        if (legal_s) begin
            dec_func_s = raw_func_s;
            dec_a_s    = raw_a_s;
            dec_b_s    = raw_b_s;
            use_rs1_s  = raw_rs1_s;
            use_rs2_s  = raw_rs2_s;
        end else begin
            dec_func_s = FK_ADD;
            dec_a_s    = 32'd0;
            dec_b_s    = 32'd0;
            use_rs1_s  = 1'b0;
            use_rs2_s  = 1'b0;
        end
    end

    assign dec_we_s = legal_s && (rd_s != 5'd0);

    function automatic logic rs_hazard(input t_reg_idx rs, input logic [NUM_REGS-1:0] busy,
                                       input logic wen, input t_reg_idx wrd,
                                       input logic sv, input logic swe, input t_reg_idx srd);
        return (rs != 5'd0) &&
               ((busy[rs] && !(wen && (wrd == rs))) || (sv && swe && (srd == rs)));
    endfunction

    logic hazard_s, accept_s, issue_hs_s;

    always_comb begin
        hazard_s = (use_rs1_s && rs_hazard(rs1_s, busy_q, wb_en, wb_rd, out_valid_q, out_we_q, out_rd_q)) ||
                   (use_rs2_s && rs_hazard(rs2_s, busy_q, wb_en, wb_rd, out_valid_q, out_we_q, out_rd_q)) ||
                   (dec_we_s && busy_q[rd_s]);
        in_ready   = !hazard_s && (!out_valid_q || out_ready);
        accept_s   = in_valid && in_ready;
        issue_hs_s = out_valid_q && out_ready && out_we_q && !flush;
    end

    // Slot load/drain; flush drops the slot even when a new word is accepted.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_func_d    = out_func_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_rd_d      = out_rd_q;
        out_we_d      = out_we_q;
        out_illegal_d = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d   = 1'b1;
            out_func_d    = dec_func_s;
            out_a_d       = dec_a_s;
            out_b_d       = dec_b_s;
            out_rd_d      = rd_s;
            out_we_d      = dec_we_s;
            out_illegal_d = !legal_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Set is applied after clear so an issue wins over a same-cycle writeback.
    always_comb begin
        busy_d = ((busy_q & ~(wb_en ? (ONE_BIT << wb_rd) : '0)) |
                  (issue_hs_s ? (ONE_BIT << out_rd_q) : '0)) & ~ONE_BIT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            out_func_q    <= FK_ADD;
            out_a_q       <= 32'd0;
            out_b_q       <= 32'd0;
            out_rd_q      <= 5'd0;
            out_we_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            busy_q        <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_func_q    <= out_func_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_rd_q      <= out_rd_d;
            out_we_q      <= out_we_d;
            out_illegal_q <= out_illegal_d;
            busy_q        <= busy_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_func    = out_func_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_rd      = out_rd_q;
    assign out_we      = out_we_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    t_func_kind  out_func;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;
    logic        out_we, out_illegal;

    int passed = 0;
    int total  = 0;

    alu_issue_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word until accepted (bounded), then clock it into the slot.
    task automatic accept(input logic [31:0] instr, input logic [31:0] pc, output bit ok);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    // Let the slot issue, then write the destination back.
    task automatic retire(input logic [4:0] rd, input logic [31:0] data);
        out_ready = 1'b1;
        step();
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_func !== FK_ADD) $display("FAIL rst_func got=%0d exp=%0d", out_func, FK_ADD); else passed++;
        total++; if ({out_a, out_b, out_rd, out_we, out_illegal} !== 71'd0)
                     $display("FAIL rst_fields got=%h/%h/%0d/%b/%b exp=0", out_a, out_b, out_rd, out_we, out_illegal);
                 else passed++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        bit ok;
        out_ready = 1'b1;
        accept(32'hFFB00093, 32'h0, ok);
        total++; if (!ok) $display("FAIL addi_accept got=stall exp=accept"); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", out_valid); else passed++;
        total++; if (out_func !== FK_ADD) $display("FAIL addi_func got=%0d exp=%0d", out_func, FK_ADD); else passed++;
        total++; if (out_a !== 32'h0) $display("FAIL addi_a got=%h exp=0", out_a); else passed++;
        total++; if (out_b !== 32'hFFFFFFFB) $display("FAIL addi_b got=%h exp=fffffffb", out_b); else passed++;
        total++; if (out_rd !== 5'd1 || out_we !== 1'b1) $display("FAIL addi_rdwe got=%0d/%b exp=1/1", out_rd, out_we); else passed++;
    endtask

    task automatic test_raw_hazard();
        step();
        in_instr = 32'h00108133;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL raw_stall0 got=%b exp=0", in_ready); else passed++;
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL raw_stall1 got=%b exp=0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL raw_noslot got=%b exp=0", out_valid); else passed++;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL raw_wb_ready got=%b exp=1", in_ready); else passed++;
        step();
        wb_en = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_rd !== 5'd2) $display("FAIL raw_slot got=%b/%0d exp=1/2", out_valid, out_rd); else passed++;
        total++; if (out_a !== 32'd7 || out_b !== 32'd7) $display("FAIL raw_bypass got=%h/%h exp=7/7", out_a, out_b); else passed++;
        step();
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h123;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_shift();
        bit ok;
        accept(32'h4020D1B3, 32'h0, ok);
        total++; if (!ok) $display("FAIL sra_accept got=stall exp=accept"); else passed++;
        total++; if (out_func !== FK_SRA) $display("FAIL sra_func got=%0d exp=%0d", out_func, FK_SRA); else passed++;
        total++; if (out_a !== 32'd7 || out_b !== 32'd3) $display("FAIL sra_ops got=%h/%h exp=7/3", out_a, out_b); else passed++;
        retire(5'd3, 32'd0);
        accept(32'h4000D1B3, 32'h0, ok);
        total++; if (!ok || out_func !== FK_SRA || out_b !== 32'd0)
                     $display("FAIL sra_x0 got=%b/%0d/%h exp=1/%0d/0", ok, out_func, out_b, FK_SRA);
                 else passed++;
        retire(5'd3, 32'd0);
        accept(32'h4030D793, 32'h0, ok);
        total++; if (!ok || out_func !== FK_SRA || out_a !== 32'd7 || out_b !== 32'd3)
                     $display("FAIL srai got=%b/%0d/%h/%h exp=1/%0d/7/3", ok, out_func, out_a, out_b, FK_SRA);
                 else passed++;
        retire(5'd15, 32'd0);
        accept(32'h0200D1B3, 32'h0, ok);
        total++; if (out_illegal !== 1'b1 || out_we !== 1'b0) $display("FAIL ill_flags got=%b/%b exp=1/0", out_illegal, out_we); else passed++;
        total++; if (out_func !== FK_ADD || out_a !== 32'd0 || out_b !== 32'd0)
                     $display("FAIL ill_ops got=%0d/%h/%h exp=%0d/0/0", out_func, out_a, out_b, FK_ADD);
                 else passed++;
        step();
    endtask

    task automatic test_auipc_x0();
        bit ok;
        accept(32'h12345297, 32'h100, ok);
        total++; if (out_func !== FK_ADD || out_rd !== 5'd5) $display("FAIL auipc_func got=%0d/%0d exp=%0d/5", out_func, out_rd, FK_ADD); else passed++;
        total++; if (out_a !== 32'h100 || out_b !== 32'h12345000) $display("FAIL auipc_ops got=%h/%h exp=100/12345000", out_a, out_b); else passed++;
        retire(5'd5, 32'd0);
        accept(32'h00100013, 32'h0, ok);
        total++; if (out_we !== 1'b0 || out_b !== 32'd1 || out_rd !== 5'd0)
                     $display("FAIL x0_we got=%b/%h/%0d exp=0/1/0", out_we, out_b, out_rd);
                 else passed++;
        step();
        in_instr = 32'h00000333;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL x0_notbusy got=%b exp=1", in_ready); else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_hold_flush();
        bit ok;
        out_ready = 1'b0;
        accept(32'h05500393, 32'h0, ok);
        in_instr = 32'h00100413;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) $display("FAIL hold_ready%0d got=%b exp=0", i, in_ready); else passed++;
            step();
            total++; if (out_valid !== 1'b1 || out_b !== 32'h55 || out_rd !== 5'd7 || out_we !== 1'b1)
                         $display("FAIL hold_fields%0d got=%b/%h/%0d/%b exp=1/55/7/1", i, out_valid, out_b, out_rd, out_we);
                     else passed++;
        end
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", out_valid); else passed++;
        out_ready = 1'b1;
        in_instr = 32'h00038493;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_nobusy got=%b exp=1", in_ready); else passed++;
        accept(32'h00038493, 32'h0, ok);
        total++; if (out_a !== 32'd0 || out_rd !== 5'd9) $display("FAIL flush_read got=%h/%0d exp=0/9", out_a, out_rd); else passed++;
        retire(5'd9, 32'd0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_instr = 32'h00100693;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got=%b exp=1", in_ready); else passed++;
        step();
        in_instr = 32'h00200713;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got=%b exp=1", in_ready); else passed++;
        total++; if (out_rd !== 5'd13 || out_b !== 32'd1) $display("FAIL b2b_first got=%0d/%h exp=13/1", out_rd, out_b); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_rd !== 5'd14 || out_b !== 32'd2)
                     $display("FAIL b2b_second got=%b/%0d/%h exp=1/14/2", out_valid, out_rd, out_b);
                 else passed++;
        step();
        wb_en = 1'b1; wb_rd = 5'd13; wb_data = 32'd1;
        step();
        wb_rd = 5'd14; wb_data = 32'd2;
        step();
        wb_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hABCD;
        step();
        wb_en = 1'b0;
        out_ready = 1'b1;
        accept(32'h00900213, 32'h0, ok);
        step();
        out_ready = 1'b0;
        accept(32'h00300513, 32'h0, ok);
        total++; if (out_valid !== 1'b1 || out_rd !== 5'd10) $display("FAIL rmid_pre got=%b/%0d exp=1/10", out_valid, out_rd); else passed++;
        reset_n = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h77;
        step();
        wb_en = 1'b0;
        reset_n = 1'b1;
        total++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_b !== 32'd0)
                     $display("FAIL rmid_slot got=%b/%0d/%h exp=0/0/0", out_valid, out_rd, out_b);
                 else passed++;
        out_ready = 1'b1;
        in_instr = 32'h000205B3;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL rmid_busy got=%b exp=1", in_ready); else passed++;
        accept(32'h000205B3, 32'h0, ok);
        total++; if (out_a !== 32'd0 || out_rd !== 5'd11) $display("FAIL rmid_x4 got=%h/%0d exp=0/11", out_a, out_rd); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw_hazard();
        test_shift();
        test_auipc_x0();
        test_hold_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
